// File: rtl/locked_adder_response_checker.sv
// Response checker for a key-locked adder: compares the adder's output against
// a golden sum per sample, accumulates sample/mismatch/Hamming-distance counts
// for one key trial, and presents a held report until it is accepted.
module locked_adder_response_checker #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned KEY_W  = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [KEY_W-1:0]    key_i,
   input  logic                vld_i,
   input  logic [DATA_W-1:0]   add1_i,
   input  logic [DATA_W-1:0]   add2_i,
   input  logic [DATA_W:0]     result_i,
   input  logic                last_i,
   output logic                busy_o,
   output logic                rpt_vld_o,
   input  logic                rpt_rdy_i,
   output logic [KEY_W-1:0]    rpt_key_o,
   output logic [CNT_W-1:0]    rpt_samples_o,
   output logic [CNT_W-1:0]    rpt_mismatch_o,
   output logic [CNT_W+5:0]    rpt_hd_o,
   output logic                rpt_pass_o
);

   localparam int unsigned RES_W = DATA_W + 1;
   localparam int unsigned HD_W  = CNT_W + 6;
   localparam int unsigned PC_W  = $clog2(RES_W + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t             state;
   logic               drain_cnt;
   logic               start_acc;
   logic               s1_vld;
   logic [RES_W-1:0]   s1_golden;
   logic [RES_W-1:0]   s1_result;
   logic [RES_W-1:0]   diff;
   logic [PC_W-1:0]    pc;
   logic [HD_W:0]      hd_sum;
   logic [CNT_W-1:0]   samples;
   logic [CNT_W-1:0]   mismatch;
   logic [HD_W-1:0]    hd;

   assign start_acc = (state == IDLE) && start_i;

   // Stage 1: register golden sum (with carry-out) and observed result
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_vld    <= 1'b0;
         s1_golden <= '0;
         s1_result <= '0;
      end else begin
         s1_vld <= (state == COLLECT) && vld_i;
         if ((state == COLLECT) && vld_i) begin
            s1_golden <= RES_W'(add1_i) + RES_W'(add2_i);
            s1_result <= result_i;
         end
      end
   end

   // Stage 2 combinational: difference vector, its popcount, widened hd sum
   always_comb begin
      diff = s1_golden ^ s1_result;
      pc   = '0;
      for (int i = 0; i < int'(RES_W); i++) begin
         pc = pc + PC_W'(diff[i]);
      end
      hd_sum = (HD_W + 1)'(hd) + (HD_W + 1)'(pc);
   end

   // Stage 2 accumulators: cleared on accepted start, saturating at all-ones
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         samples  <= '0;
         mismatch <= '0;
         hd       <= '0;
      end else if (start_acc) begin
         samples  <= '0;
         mismatch <= '0;
         hd       <= '0;
      end else if (s1_vld) begin
         if (samples != '1) samples <= samples + CNT_W'(1);
         if ((diff != '0) && (mismatch != '1)) mismatch <= mismatch + CNT_W'(1);
         hd <= hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];
      end
   end

   // Trial control FSM with registered busy/report outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         drain_cnt  <= 1'b0;
         rpt_key_o  <= '0;
         busy_o     <= 1'b0;
         rpt_vld_o  <= 1'b0;
         rpt_pass_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  state      <= COLLECT;
                  rpt_key_o  <= key_i;
                  busy_o     <= 1'b1;
                  rpt_pass_o <= 1'b0;
               end
            end
            COLLECT: begin
               if (vld_i && last_i) begin
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
               end
            end
            DRAIN: begin
               // Two cycles let the final sample reach the accumulators
               if (drain_cnt) begin
                  state      <= REPORT;
                  rpt_vld_o  <= 1'b1;
                  rpt_pass_o <= (mismatch == '0) && (samples != '0);
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            REPORT: begin
               if (rpt_rdy_i) begin
                  state     <= IDLE;
                  rpt_vld_o <= 1'b0;
                  busy_o    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rpt_samples_o  = samples;
   assign rpt_mismatch_o = mismatch;
   assign rpt_hd_o       = hd;

endmodule

// File: tb/tb_locked_adder_response_checker.sv
// Directed self-checking bench for locked_adder_response_checker.
module tb_locked_adder_response_checker;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i;
   logic [63:0]   key_i;
   logic          vld_i;
   logic [31:0]   add1_i;
   logic [31:0]   add2_i;
   logic [32:0]   result_i;
   logic          last_i;
   logic          busy_o;
   logic          rpt_vld_o;
   logic          rpt_rdy_i;
   logic [63:0]   rpt_key_o;
   logic [15:0]   rpt_samples_o;
   logic [15:0]   rpt_mismatch_o;
   logic [21:0]   rpt_hd_o;
   logic          rpt_pass_o;

   int tests  = 0;
   int failed = 0;

   localparam logic [63:0] KEY1 = 64'h5A21065A09A7176D;
   localparam logic [63:0] KEY2 = 64'h0123456789ABCDEF;
   localparam logic [63:0] KEY3 = 64'hFEDCBA9876543210;

   locked_adder_response_checker dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .key_i          (key_i),
      .vld_i          (vld_i),
      .add1_i         (add1_i),
      .add2_i         (add2_i),
      .result_i       (result_i),
      .last_i         (last_i),
      .busy_o         (busy_o),
      .rpt_vld_o      (rpt_vld_o),
      .rpt_rdy_i      (rpt_rdy_i),
      .rpt_key_o      (rpt_key_o),
      .rpt_samples_o  (rpt_samples_o),
      .rpt_mismatch_o (rpt_mismatch_o),
      .rpt_hd_o       (rpt_hd_o),
      .rpt_pass_o     (rpt_pass_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] r, input logic l);
      vld_i    = 1'b1;
      add1_i   = a;
      add2_i   = b;
      result_i = r;
      last_i   = l;
      step();
      vld_i  = 1'b0;
      last_i = 1'b0;
   endtask

   task automatic open_trial(input logic [63:0] k);
      key_i   = k;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic accept();
      rpt_rdy_i = 1'b1;
      step();
      rpt_rdy_i = 1'b0;
      check("accept_vld", 64'(rpt_vld_o), 64'd0);
      check("accept_busy", 64'(busy_o), 64'd0);
   endtask

   initial begin
      rst_ni    = 1'b0;
      start_i   = 1'b0;
      key_i     = '0;
      vld_i     = 1'b0;
      add1_i    = '0;
      add2_i    = '0;
      result_i  = '0;
      last_i    = 1'b0;
      rpt_rdy_i = 1'b0;
      step();
      step();
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_vld", 64'(rpt_vld_o), 64'd0);
      check("rst_pass", 64'(rpt_pass_o), 64'd0);
      check("rst_key", rpt_key_o, 64'd0);
      check("rst_samples", 64'(rpt_samples_o), 64'd0);
      check("rst_hd", 64'(rpt_hd_o), 64'd0);
      rst_ni = 1'b1;
      step();

      // Single correct sample; report latency and contents
      open_trial(KEY1);
      check("t1_busy", 64'(busy_o), 64'd1);
      check("t1_key", rpt_key_o, KEY1);
      send(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC, 1'b1);
      check("t1_vld_c0", 64'(rpt_vld_o), 64'd0);
      step();
      check("t1_vld_c1", 64'(rpt_vld_o), 64'd0);
      step();
      check("t1_vld_c2", 64'(rpt_vld_o), 64'd1);
      check("t1_samples", 64'(rpt_samples_o), 64'd1);
      check("t1_mismatch", 64'(rpt_mismatch_o), 64'd0);
      check("t1_hd", 64'(rpt_hd_o), 64'd0);
      check("t1_pass", 64'(rpt_pass_o), 64'd1);
      accept();

      // Start+vld same cycle drops sample; dropped carry counts one bit
      key_i    = KEY2;
      start_i  = 1'b1;
      vld_i    = 1'b1;
      add1_i   = 32'h0;
      add2_i   = 32'h0;
      result_i = 33'h1FFFFFFFF;
      step();
      start_i = 1'b0;
      vld_i   = 1'b0;
      send(32'h55555555, 32'hAAAAAAAA, 33'h0FFFFFFFF, 1'b0);
      send(32'hFFFFFFFF, 32'h00000001, 33'h000000000, 1'b1);
      vld_i    = 1'b1;
      result_i = 33'h1FFFFFFFF;
      step();
      step();
      vld_i = 1'b0;
      check("t2_vld", 64'(rpt_vld_o), 64'd1);
      check("t2_samples", 64'(rpt_samples_o), 64'd2);
      check("t2_mismatch", 64'(rpt_mismatch_o), 64'd1);
      check("t2_hd", 64'(rpt_hd_o), 64'd1);
      check("t2_pass", 64'(rpt_pass_o), 64'd0);

      // Report held while rdy low and other inputs toggle
      for (int i = 0; i < 10; i++) begin
         vld_i   = ~vld_i;
         start_i = ~start_i;
         key_i   = ~key_i;
         last_i  = ~last_i;
         step();
      end
      vld_i   = 1'b0;
      start_i = 1'b0;
      last_i  = 1'b0;
      check("t3_vld", 64'(rpt_vld_o), 64'd1);
      check("t3_key", rpt_key_o, KEY2);
      check("t3_samples", 64'(rpt_samples_o), 64'd2);
      check("t3_mismatch", 64'(rpt_mismatch_o), 64'd1);
      check("t3_hd", 64'(rpt_hd_o), 64'd1);
      check("t3_pass", 64'(rpt_pass_o), 64'd0);
      accept();

      // rdy in IDLE has no effect
      rpt_rdy_i = 1'b1;
      step();
      rpt_rdy_i = 1'b0;
      check("t4_vld", 64'(rpt_vld_o), 64'd0);
      check("t4_busy", 64'(busy_o), 64'd0);

      // Sixteen samples with 33 differing bits each
      open_trial(KEY3);
      for (int i = 0; i < 16; i++) begin
         send(32'h00000001, 32'hDEAFBEEF, 33'h12150410F, (i == 15));
      end
      step();
      step();
      check("t5_vld", 64'(rpt_vld_o), 64'd1);
      check("t5_samples", 64'(rpt_samples_o), 64'd16);
      check("t5_mismatch", 64'(rpt_mismatch_o), 64'd16);
      check("t5_hd", 64'(rpt_hd_o), 64'd528);
      check("t5_pass", 64'(rpt_pass_o), 64'd0);
      accept();

      // Asynchronous reset mid-trial discards it
      open_trial(KEY1);
      send(32'h1, 32'h1, 33'h3, 1'b0);
      send(32'h2, 32'h2, 33'h4, 1'b0);
      send(32'h3, 32'h3, 33'h6, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_busy", 64'(busy_o), 64'd0);
      check("t6_vld", 64'(rpt_vld_o), 64'd0);
      check("t6_samples", 64'(rpt_samples_o), 64'd0);
      check("t6_key", rpt_key_o, 64'd0);
      step();
      rst_ni = 1'b1;
      begin
         int vld_seen;
         vld_seen = 0;
         for (int i = 0; i < 6; i++) begin
            step();
            if (rpt_vld_o !== 1'b0 || busy_o !== 1'b0) vld_seen++;
         end
         check("t6_quiet", 64'(vld_seen), 64'd0);
      end
      open_trial(KEY2);
      check("t6_restart_samples", 64'(rpt_samples_o), 64'd0);
      send(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC, 1'b1);
      step();
      step();
      check("t6_new_vld", 64'(rpt_vld_o), 64'd1);
      check("t6_new_samples", 64'(rpt_samples_o), 64'd1);
      check("t6_new_pass", 64'(rpt_pass_o), 64'd1);
      accept();

      // Saturation: 65537 mismatching samples, one differing bit each
      open_trial(KEY3);
      vld_i    = 1'b1;
      add1_i   = 32'h0;
      add2_i   = 32'h1;
      result_i = 33'h0;
      last_i   = 1'b0;
      repeat (65536) step();
      last_i = 1'b1;
      step();
      vld_i  = 1'b0;
      last_i = 1'b0;
      step();
      step();
      check("t7_vld", 64'(rpt_vld_o), 64'd1);
      check("t7_samples", 64'(rpt_samples_o), 64'hFFFF);
      check("t7_mismatch", 64'(rpt_mismatch_o), 64'hFFFF);
      check("t7_hd", 64'(rpt_hd_o), 64'd65537);
      check("t7_pass", 64'(rpt_pass_o), 64'd0);
      accept();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
